// File: rtl/mult_shift_add_32bit_pkg.sv
// -----------------------------------------------------------------------------
// mult_shift_add_32bit_pkg
// Shared constants and types for the sequential shift/add multiplier.
//   WIDTH     : operand width (fixed by the 32-bit adder datapath)
//   state_t   : FSM state encoding (IDLE / RUN / DONE)
//   ITER_LAST : count value of the final RUN iteration
// -----------------------------------------------------------------------------
package mult_shift_add_32bit_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage : mult_shift_add_32bit_pkg

// File: rtl/adder_32bit.sv
// -----------------------------------------------------------------------------
// adder_32bit
// Existing combinational 32-bit adder; used as the accumulate datapath of the
// MUL unit. Carry-out is not exported.
//   a, b : addends (32 bit)
//   y    : sum modulo 2^32
// -----------------------------------------------------------------------------
module adder_32bit
  import mult_shift_add_32bit_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule : adder_32bit

// File: rtl/mult_shift_add_32bit.sv
// -----------------------------------------------------------------------------
// mult_shift_add_32bit
// Sequential unsigned 32x32 -> 64 multiplier. One shift/add step per cycle for
// a fixed 32 RUN cycles, using a single adder_32bit for hi + mcand.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request a multiply (only honoured when not busy)
//   a, b    : multiplicand / multiplier, captured on an accepted start
//   busy    : high while iterating
//   done    : one-cycle pulse when product is valid
//   product : 64-bit result, held until the next result lands
// -----------------------------------------------------------------------------
module mult_shift_add_32bit #(
  parameter int WIDTH = 32  // only 32 is legal: the adder is fixed width
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  import mult_shift_add_32bit_pkg::state_t;
  import mult_shift_add_32bit_pkg::IDLE;
  import mult_shift_add_32bit_pkg::RUN;
  import mult_shift_add_32bit_pkg::DONE;
  import mult_shift_add_32bit_pkg::ITER_LAST;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [4:0]           count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     sum_y;
  logic                 sum_c;

  adder_32bit u_adder (
    .a (hi_q),
    .b (mcand_q),
    .y (sum_y)
  );

  // Adder has no carry port: recover carry-out from the operand and sum MSBs.
  // With equal MSBs the carry is their value; with differing MSBs a carry
  // into bit 31 occurred exactly when the sum MSB came out 0.
  assign sum_c = (hi_q[WIDTH-1] & mcand_q[WIDTH-1]) |
                 ((hi_q[WIDTH-1] ^ mcand_q[WIDTH-1]) & ~sum_y[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a;
          lo_d    = b;
          hi_d    = '0;
          count_d = '0;
          state_d = RUN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      RUN: begin
        // {hi,lo} shifts right by one; when the multiplier bit is set the
        // upper half is replaced by the 33-bit sum first.
        if (lo_q[0]) begin
          {hi_d, lo_d} = {sum_c, sum_y, lo_q[WIDTH-1:1]};
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == ITER_LAST) begin
          state_d   = DONE;
          product_d = {hi_d, lo_d};
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule : mult_shift_add_32bit

// File: tb/tb_mult_shift_add_32bit.sv
// -----------------------------------------------------------------------------
// tb_mult_shift_add_32bit
// Self-checking bench: vector table, randomized operands against an
// arithmetic reference (a*b in 64 bits), and hand sequences for busy-ignore,
// back-to-back start and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_mult_shift_add_32bit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int n_cmp;
  int n_bad;

  mult_shift_add_32bit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a_i),
    .b       (b_i),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return 64'(x) * 64'(y);
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h required 0x%016h", name, got, exp);
    end
  endtask

  // Issue one multiply and wait for done; reports product, edges from accept
  // to done, and number of busy cycles observed.
  task automatic run_mul(input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] p, output int lat, output int nbusy);
    @(negedge clk);
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      @(posedge clk);
      #1;
      lat++;
    end
    p = product;
  endtask

  task automatic mul_and_check(input string tag, input logic [31:0] x,
                               input logic [31:0] y, input logic [63:0] exp);
    logic [63:0] p;
    int          lat;
    int          nbusy;
    run_mul(x, y, p, lat, nbusy);
    check({tag, " product"}, p, exp);
    check({tag, " latency"}, 64'(lat), 64'd32);
    check({tag, " busy cycles"}, 64'(nbusy), 64'd32);
    check({tag, " busy at done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, " done pulse width"}, 64'(done), 64'd0);
    check({tag, " product held"}, product, exp);
    $display("mul a=0x%08h b=0x%08h -> product=0x%016h latency=%0d", x, y, p, lat);
  endtask

  initial begin
    vec_t        vecs[5];
    logic [63:0] p;
    int          lat;
    int          nbusy;
    int          ndone;
    int          done_at;
    logic [31:0] rx;
    logic [31:0] ry;

    n_cmp = 0;
    n_bad = 0;
    start = 1'b0;
    a_i   = '0;
    b_i   = '0;
    rst_n = 1'b0;

    vecs[0] = '{32'hFFFF_FFFB, 32'h0000_0003, 64'h0000_0002_FFFF_FFF1};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
    vecs[3] = '{32'h0000_0001, 32'h1234_5678, 64'h0000_0000_1234_5678};
    vecs[4] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      mul_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Randomized operands against the arithmetic reference.
    for (int i = 0; i < 8; i++) begin
      rx = $urandom;
      ry = $urandom;
      if (i == 0) rx = 32'hFFFF_FFFF;
      mul_and_check($sformatf("rand%0d", i), rx, ry, ref_mul(rx, ry));
    end

    // Busy-ignore: a second start mid-run must not disturb the result.
    @(negedge clk);
    a_i = 32'd7; b_i = 32'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ndone = 0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      if (c == 10) begin
        a_i = 32'd9; b_i = 32'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == 32) p = product;
    end
    start = 1'b0;
    check("ignore product", p, 64'h2A);
    check("ignore done count", 64'(ndone), 64'd1);
    check("ignore done edge", 64'(done_at), 64'd32);
    $display("busy-ignore a=7 b=6 (start a=9 b=9 at cycle 10) -> product=0x%016h dones=%0d", p, ndone);

    // Back-to-back: new start issued during the DONE cycle.
    run_mul(32'd7, 32'd6, p, lat, nbusy);
    check("b2b first product", p, 64'h2A);
    a_i = 32'd3; b_i = 32'd5; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b accepted busy", 64'(busy), 64'd1);
    check("b2b done cleared", 64'(done), 64'd0);
    check("b2b product kept", product, 64'h2A);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b second product", product, 64'hF);
    check("b2b second latency", 64'(lat), 64'd32);
    $display("back-to-back a=3 b=5 -> product=0x%016h latency=%0d", product, lat);

    // Reset in the middle of an operation.
    @(negedge clk);
    a_i = 32'hFFFF_FFFB; b_i = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("midrst busy before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check("midrst product", product, 64'd0);
    $display("reset mid-run -> busy=%0b done=%0b product=0x%016h", busy, done, product);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mul_and_check("after reset", 32'd2, 32'd3, 64'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_mult_shift_add_32bit
